// File: rtl/fb_pkg.sv
// Shared framebuffer types and defaults for the shade output path.
// A write entry carries the linear word address and the packed ARGB data word.
package fb_pkg;

    localparam int unsigned FB_WIDTH_DFLT  = 160;
    localparam int unsigned FB_HEIGHT_DFLT = 120;
    localparam int unsigned FB_ADDR_W      = 15;

    localparam logic [7:0] ALPHA_OPAQUE = 8'hFF;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [31:0]          data;
    } fb_write_t;

endpackage

// File: rtl/fb_write_fifo.sv
// Synchronous first-word fall-through FIFO of framebuffer writes.
// A push is accepted while full when a pop happens in the same cycle.
module fb_write_fifo
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fb_write_t        push_data,
    input  logic             pop,
    output fb_write_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fb_write_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/shade_output_collector.sv
// Collects ray core shade outputs round-robin, maps pixels to framebuffer addresses,
// buffers the writes and tracks per-frame pixel and dropped-pixel counts.
module shade_output_collector
    import fb_pkg::*;
#(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned FB_WIDTH   = FB_WIDTH_DFLT,
    parameter int unsigned FB_HEIGHT  = FB_HEIGHT_DFLT,
    parameter int unsigned ADDR_W     = FB_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        in_valid,
    output logic [NUM_CORES-1:0]        in_ready,
    input  logic [NUM_CORES-1:0][15:0]  in_x,
    input  logic [NUM_CORES-1:0][15:0]  in_y,
    input  logic [NUM_CORES-1:0][23:0]  in_rgb,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [31:0]                 wr_data,
    output logic                        frame_done,
    output logic [ADDR_W-1:0]           pixel_count,
    output logic [15:0]                 drop_count
);

    localparam int unsigned PTR_W        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FRAME_PIXELS = FB_WIDTH * FB_HEIGHT;

    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  grant;
    logic [PTR_W-1:0]  grant_next;
    int unsigned       idx;
    logic              any_valid;
    logic              space_ok;
    logic              accept;

    logic              stage_valid_q;
    logic              stage_in_range_q;
    logic [ADDR_W-1:0] stage_addr_q;
    logic [23:0]       stage_rgb_q;

    logic [ADDR_W-1:0] pixel_count_q;
    logic              frame_done_q;
    logic [15:0]       drop_count_q;

    logic [15:0]       sel_x;
    logic [15:0]       sel_y;
    logic              sel_in_range;

    fb_write_t         push_data;
    fb_write_t         fifo_head;
    logic              fifo_push;
    logic              fifo_empty;
    logic              fifo_full_unused;
    logic [CNT_W-1:0]  fifo_count;
    logic              wr_fire;

    // First valid core at or above the pointer, wrapping modulo NUM_CORES.
    always_comb begin
        grant     = rr_ptr_q;
        any_valid = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_CORES;
            if (!any_valid && in_valid[PTR_W'(idx)]) begin
                any_valid = 1'b1;
                grant     = PTR_W'(idx);
            end
        end
    end

    // Reserve a FIFO slot for the entry in the stage so its push can never be refused.
    assign space_ok = (32'(fifo_count) + 32'(stage_valid_q)) < FIFO_DEPTH;

    always_comb begin
        in_ready = '0;
        if (!reset && any_valid && space_ok) in_ready[grant] = 1'b1;
    end

    assign accept       = |(in_valid & in_ready);
    assign grant_next   = (32'(grant) == NUM_CORES - 1) ? '0 : grant + PTR_W'(1);
    assign sel_x        = in_x[grant];
    assign sel_y        = in_y[grant];
    assign sel_in_range = (32'(sel_x) < FB_WIDTH) && (32'(sel_y) < FB_HEIGHT);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q         <= '0;
            stage_valid_q    <= 1'b0;
            stage_in_range_q <= 1'b0;
            stage_addr_q     <= '0;
            stage_rgb_q      <= '0;
        end else begin
            stage_valid_q <= accept;
            if (accept) begin
                rr_ptr_q         <= grant_next;
                stage_in_range_q <= sel_in_range;
                stage_addr_q     <= ADDR_W'(32'(sel_y) * FB_WIDTH + 32'(sel_x));
                stage_rgb_q      <= in_rgb[grant];
            end
        end
    end

    assign fifo_push      = stage_valid_q && stage_in_range_q;
    assign push_data.addr = FB_ADDR_W'(stage_addr_q);
    assign push_data.data = {ALPHA_OPAQUE, stage_rgb_q};

    fb_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (wr_ready),
        .head      (fifo_head),
        .full      (fifo_full_unused),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign wr_valid = !fifo_empty;
    assign wr_addr  = ADDR_W'(fifo_head.addr);
    assign wr_data  = fifo_head.data;
    assign wr_fire  = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_count_q <= '0;
            frame_done_q  <= 1'b0;
            drop_count_q  <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (wr_fire) begin
                if (pixel_count_q == ADDR_W'(FRAME_PIXELS - 1)) begin
                    pixel_count_q <= '0;
                    frame_done_q  <= 1'b1;
                end else begin
                    pixel_count_q <= pixel_count_q + ADDR_W'(1);
                end
            end
            if (stage_valid_q && !stage_in_range_q && drop_count_q != 16'hFFFF) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    assign pixel_count = pixel_count_q;
    assign frame_done  = frame_done_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_shade_output_collector.sv
// Randomised bench for shade_output_collector with a queue-based scoreboard;
// a negedge monitor checks arbitration, counters and every framebuffer write.
module tb_shade_output_collector;

    localparam int NC    = 4;
    localparam int W     = 160;
    localparam int H     = 120;
    localparam int AW    = 15;
    localparam int D     = 8;
    localparam int TOTAL = W * H;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NC-1:0]         in_valid;
    logic [NC-1:0]         in_ready;
    logic [NC-1:0][15:0]   in_x;
    logic [NC-1:0][15:0]   in_y;
    logic [NC-1:0][23:0]   in_rgb;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [AW-1:0]         wr_addr;
    logic [31:0]           wr_data;
    logic                  frame_done;
    logic [AW-1:0]         pixel_count;
    logic [15:0]           drop_count;

    always #5 clk = ~clk;

    shade_output_collector #(
        .NUM_CORES  (NC),
        .FB_WIDTH   (W),
        .FB_HEIGHT  (H),
        .ADDR_W     (AW),
        .FIFO_DEPTH (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_rgb      (in_rgb),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_done  (frame_done),
        .pixel_count (pixel_count),
        .drop_count  (drop_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    exp_t exp_q[$];
    int   m_ptr = 0;
    int   m_pix = 0;
    int   m_drop = 0;
    bit   last_in = 0;
    bit   last_oor = 0;
    bit   fd_exp = 0;
    int   acc_total = 0;
    int   hs_total = 0;
    int   fd_pulses = 0;
    int   acc_core[NC];

    always @(negedge clk) begin
        if (reset) begin
            check("in_ready_during_reset", 64'(in_ready), 64'd0);
            exp_q.delete();
            m_ptr = 0; m_pix = 0; m_drop = 0;
            last_in = 0; last_oor = 0; fd_exp = 0;
        end else begin : mon
            int g;
            bit found;
            int occ;
            int x;
            int y;
            logic [NC-1:0] exp_rdy;
            exp_t w;
            exp_t e;

            check("frame_done", 64'(frame_done), 64'(fd_exp));
            check("pixel_count", 64'(pixel_count), 64'(m_pix));
            check("drop_count", 64'(drop_count), 64'(m_drop));
            check("wr_valid", 64'(wr_valid), 64'(exp_q.size() > (last_in ? 1 : 0)));

            found = 0;
            g = 0;
            for (int i = 0; i < NC; i++) begin
                if (!found && in_valid[(m_ptr + i) % NC]) begin
                    found = 1;
                    g = (m_ptr + i) % NC;
                end
            end
            occ = exp_q.size() + (last_oor ? 1 : 0);
            exp_rdy = '0;
            if (found && occ < D) exp_rdy[g] = 1'b1;
            check("in_ready", 64'(in_ready), 64'(exp_rdy));

            if (wr_valid && wr_ready) begin
                check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(w.addr));
                    check("wr_data", 64'(wr_data), 64'(w.data));
                end
                hs_total++;
                fd_exp = (m_pix == TOTAL - 1);
                m_pix = (m_pix + 1) % TOTAL;
            end else begin
                fd_exp = 0;
            end
            if (frame_done) fd_pulses++;
            if (last_oor && m_drop < 65535) m_drop++;

            last_in = 0;
            last_oor = 0;
            if (exp_rdy != '0) begin
                x = int'(in_x[g]);
                y = int'(in_y[g]);
                if (x < W && y < H) begin
                    e.addr = AW'(y * W + x);
                    e.data = {8'hFF, in_rgb[g]};
                    exp_q.push_back(e);
                    last_in = 1;
                end else begin
                    last_oor = 1;
                end
                acc_total++;
                acc_core[g]++;
                m_ptr = (g + 1) % NC;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_pixels(input int xmax, input int ymax);
        for (int i = 0; i < NC; i++) begin
            in_x[i]   = 16'($urandom_range(xmax));
            in_y[i]   = 16'($urandom_range(ymax));
            in_rgb[i] = 24'($urandom);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        in_valid = '0;
        wr_ready = 1'b1;
        while ((exp_q.size() != 0 || wr_valid) && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a0;
        int h0;
        int d0;
        int f0;
        int c0[NC];
        int n;

        for (int i = 0; i < NC; i++) acc_core[i] = 0;
        in_valid = '0; in_x = '0; in_y = '0; in_rgb = '0; wr_ready = 1'b0;
        repeat (3) tick();
        check("reset_wr_valid", 64'(wr_valid), 64'd0);
        check("reset_pixel_count", 64'(pixel_count), 64'd0);
        check("reset_drop_count", 64'(drop_count), 64'd0);
        reset = 1'b0;

        // Single pixel from core 2: address 2*160+3 = 323, two-cycle latency
        wr_ready = 1'b1;
        in_valid = 4'b0100;
        in_x[2] = 16'd3; in_y[2] = 16'd2; in_rgb[2] = 24'h123456;
        tick();
        in_valid = '0;
        check("single_not_early", 64'(wr_valid), 64'd0);
        tick();
        check("single_wr_valid", 64'(wr_valid), 64'd1);
        check("single_wr_addr", 64'(wr_addr), 64'd323);
        check("single_wr_data", 64'(wr_data), 64'hFF123456);
        tick();
        check("single_pixel_count", 64'(pixel_count), 64'd1);

        // All cores valid: each core receives one grant in four
        for (int i = 0; i < NC; i++) c0[i] = acc_core[i];
        in_valid = '1;
        repeat (40) begin
            rand_pixels(W - 1, H - 1);
            tick();
        end
        for (int i = 0; i < NC; i++) check("rr_share", 64'(acc_core[i] - c0[i]), 64'd10);
        drain("rr");

        // Backpressure: exactly FIFO_DEPTH accepts, then stall, then ordered release
        a0 = acc_total;
        h0 = hs_total;
        wr_ready = 1'b0;
        in_valid = '1;
        repeat (20) begin
            rand_pixels(W - 1, H - 1);
            tick();
        end
        check("bp_accepts", 64'(acc_total - a0), 64'(D));
        check("bp_in_ready_zero", 64'(in_ready), 64'd0);
        drain("bp");
        check("bp_writes", 64'(hs_total - h0), 64'(D));

        // Out-of-range pixel is dropped, following pixel (0,0) writes address 0
        d0 = m_drop;
        h0 = hs_total;
        in_valid = 4'b0001;
        in_x[0] = 16'd160; in_y[0] = 16'd0;
        tick();
        in_x[0] = 16'd0; in_y[0] = 16'd0;
        tick();
        drain("oor");
        check("oor_drop_delta", 64'(drop_count), 64'(d0 + 1));
        check("oor_writes", 64'(hs_total - h0), 64'd1);

        // Random traffic with random backpressure and some out-of-range coordinates
        repeat (2000) begin
            in_valid = NC'($urandom);
            rand_pixels(175, 135);
            wr_ready = ($urandom_range(99) < 70);
            tick();
        end
        drain("rand");

        // Full frame from a clean reset
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        a0 = acc_total;
        h0 = hs_total;
        f0 = fd_pulses;
        wr_ready = 1'b1;
        n = 0;
        while (acc_total - a0 < TOTAL && n < 25000) begin
            in_valid = '1;
            rand_pixels(W - 1, H - 1);
            tick();
            n++;
        end
        check("frame_accepts", 64'(acc_total - a0), 64'(TOTAL));
        drain("frame");
        check("frame_writes", 64'(hs_total - h0), 64'(TOTAL));
        check("frame_done_pulses", 64'(fd_pulses - f0), 64'd1);
        check("frame_pixel_count_wrapped", 64'(pixel_count), 64'd0);

        // Reset with five entries buffered discards them all
        wr_ready = 1'b0;
        in_valid = '1;
        repeat (5) begin
            rand_pixels(W - 1, H - 1);
            tick();
        end
        in_valid = '0;
        tick();
        check("pre_reset_buffered", 64'(exp_q.size()), 64'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post_reset_wr_valid", 64'(wr_valid), 64'd0);
        check("post_reset_pixel_count", 64'(pixel_count), 64'd0);
        wr_ready = 1'b1;
        repeat (4) tick();
        check("post_reset_no_stale", 64'(wr_valid), 64'd0);
        in_valid = '1;
        repeat (8) begin
            rand_pixels(W - 1, H - 1);
            tick();
        end
        drain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
